// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with registered result and flags on a valid/ready output.
// Optional iterative shift-add multiplier (opcode 1000) enabled by defining ALU_MUL_EN.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_MUL = 4'h8
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] res;
  logic             c, ov, err;
  logic             xfer, load_res;
  logic [SHW-1:0]   amt;

  assign amt = B[SHW-1:0];

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic               is_mul, mul_done;
  logic [2*WIDTH-1:0] acc, acc_nx, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

  always_comb begin
    res = '0;
    c   = 1'b0;
    ov  = 1'b0;
    err = 1'b0;
`ifdef ALU_MUL_EN
    is_mul = 1'b0;
`endif
    case (ALU_Sel)
      OP_ADD: begin
        {c, res} = {1'b0, A} + {1'b0, B};
        ov = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        {c, res} = {1'b0, A} - {1'b0, B};
        ov = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      // The extra guard bit catches the last bit shifted out; it stays 0 for amount 0.
      OP_SHL: {c, res} = {1'b0, A} << amt;
      OP_SHR: {res, c} = {A, 1'b0} >> amt;
`ifdef ALU_MUL_EN
      OP_MUL: is_mul = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ALU_MUL_EN
    mul_done  = 1'b0;
`endif
    case (state)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
`ifdef ALU_MUL_EN
      BUSY: mul_done = (cnt == LAST);
`endif
      default: ;
    endcase
    xfer = in_valid && in_ready;
`ifdef ALU_MUL_EN
    load_res = xfer && !is_mul;
    if (xfer)                           state_n = is_mul ? BUSY : HOLD;
    else if (mul_done)                  state_n = HOLD;
    else if (state == HOLD && out_ready) state_n = IDLE;
`else
    load_res = xfer;
    if (xfer)                           state_n = HOLD;
    else if (state == HOLD && out_ready) state_n = IDLE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Overflow <= 1'b0;
      Err      <= 1'b0;
    end else if (load_res) begin
      ALU_Out  <= res;
      CarryOut <= c;
      Zero     <= (res == '0);
      Negative <= res[WIDTH-1];
      Overflow <= ov;
      Err      <= err;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      ALU_Out  <= acc_nx[WIDTH-1:0];
      CarryOut <= |acc_nx[2*WIDTH-1:WIDTH];
      Zero     <= (acc_nx[WIDTH-1:0] == '0);
      Negative <= acc_nx[WIDTH-1];
      Overflow <= 1'b0;
      Err      <= 1'b0;
    end
`endif
  end

`ifdef ALU_MUL_EN
  // One partial product per cycle; the final sum is taken from acc_nx on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (xfer && is_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8); covers the multiplier when ALU_MUL_EN is defined.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_Sel;
  logic         in_valid, in_ready;
  logic [W-1:0] ALU_Out;
  logic         CarryOut, Zero, Negative, Overflow, Err;
  logic         out_valid, out_ready;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Err(Err), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c, z, n, v, e;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } vec_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   last_mul = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    int   ia, ib, sa, sbv, t, amt;
    e   = '0;
    ia  = int'(a);
    ib  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    amt = int'(b[2:0]);
    case (op)
      4'h0: begin t = ia + ib; e.r = t[7:0]; e.c = (t > 255);
                  t = sa + sbv; e.v = (t > 127) || (t < -128); end
      4'h1: begin t = ia - ib; e.r = t[7:0]; e.c = (ia < ib);
                  t = sa - sbv; e.v = (t > 127) || (t < -128); end
      4'h2: e.r = a & b;
      4'h3: e.r = a | b;
      4'h4: e.r = a ^ b;
      4'h5: e.r = ~a;
      4'h6: begin t = ia << amt; e.r = t[7:0]; e.c = (amt != 0) && t[8]; end
      4'h7: begin t = ia >> amt; e.r = t[7:0];
                  e.c = (amt != 0) && (((ia >> (amt - 1)) & 1) == 1); end
`ifdef ALU_MUL_EN
      4'h8: begin t = ia * ib; e.r = t[7:0]; e.c = (t > 255); end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_out",  ALU_Out,  e.r);
        check("carry",    CarryOut, e.c);
        check("zero",     Zero,     e.z);
        check("negative", Negative, e.n);
        check("overflow", Overflow, e.v);
        check("err",      Err,      e.e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input bit b2b);
    int waited;
    A = a; B = b; ALU_Sel = op; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    if (b2b && !last_mul) begin
      check("b2b_in_ready", in_ready, 1);
      check("lat1_out_valid", out_valid, 1);
    end
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else sb.push_back(model(a, b, op));
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_mul = (op == 4'h8);
`ifndef ALU_MUL_EN
    last_mul = 1'b0;
`endif
  endtask

  vec_t dv[15] = '{
    {8'h7F, 8'h01, 4'h0}, {8'h02, 8'h03, 4'h1}, {8'h05, 8'h05, 4'h1},
    {8'h81, 8'h01, 4'h6}, {8'h81, 8'h03, 4'h7}, {8'h5A, 8'h08, 4'h6},
    {8'hF0, 8'h3C, 4'h2}, {8'hF0, 8'h0C, 4'h3}, {8'hFF, 8'h0F, 4'h4},
    {8'h0F, 8'hAA, 4'h5}, {8'hFF, 8'h01, 4'h0}, {8'h80, 8'h01, 4'h1},
    {8'h12, 8'h34, 4'hB}, {8'h03, 8'h05, 4'h8}, {8'h7F, 8'h81, 4'hF}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", ALU_Out, 0);
    check("rst_flags", {CarryOut, Zero, Negative, Overflow, Err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) send(dv[i].a, dv[i].b, dv[i].op, i != 0);

    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), gap == 0);
    end
    repeat (W + 3) begin @(posedge clk); #1; end

    // Backpressure: ADD result held, XOR waiting
    out_ready = 1'b0;
    send(8'h11, 8'h22, 4'h0, 1'b0);
    A = 8'h3C; B = 8'h55; ALU_Sel = 4'h4; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_alu_out", ALU_Out, 8'h33);
      check("stall_flags", {CarryOut, Zero, Negative, Overflow, Err}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    sb.push_back(model(8'h3C, 8'h55, 4'h4));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("xor_out_valid", out_valid, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    A = 8'h10; B = 8'h11; ALU_Sel = 4'h8; in_valid = 1'b1;
    @(negedge clk);
    check("mul_accept", in_ready, 1);
    sb.push_back(model(8'h10, 8'h11, 4'h8));
    @(posedge clk); #1;
    in_valid = 1'b0;
    gap = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) gap++;
    end
    check("mul_busy_cycles", gap, W);
    @(posedge clk); #1;
    @(posedge clk); #1;

    A = 8'hFF; B = 8'hFF; ALU_Sel = 4'h8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("mulrst_out_valid", out_valid, 0);
    check("mulrst_in_ready", in_ready, 1);
    check("mulrst_alu_out", ALU_Out, 0);
    check("mulrst_flags", {CarryOut, Zero, Negative, Overflow, Err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mulrst_no_result", seen, 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
